// File: rtl/ex_issue_scheduler.sv
// Issue scheduler for the single execute lane (ALU/branch, pipelined multiplier, load port).
// Latency: grant is combinational from req/state (zero cycles); rr_ptr and wb_busy update on clock.
// Backpressure: ic_stall freezes issue and state; squash kills issue and clears state next edge.
//
// Ports:
//   clock_i, reset_i      clock, asynchronous active-high reset
//   req_valid_i           per-entry ready-to-issue
//   req_fu_i              per-entry FU class at [2i+1:2i]: 00 ALU, 01 MULT, 10 LOAD, 11 BRANCH
//   dmem_busy_i           load port unavailable this cycle
//   ic_stall_i, squash_i  downstream stall, mispredict flush
//   grant_valid_o/idx_o/fu_o   issued entry (idx/fu forced to 0 when no grant)
//   wb_busy_o             writeback reservation; bit k-1 = slot k cycles ahead claimed
// Optional: define EX_SCHED_STATS_EN to add saturating stat_stall_cycles_o / stat_wb_block_cycles_o.
module ex_issue_scheduler #(
    parameter int RS_SIZE  = 8,
    parameter int MULT_LAT = 4
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic [RS_SIZE-1:0]         req_valid_i,
    input  logic [2*RS_SIZE-1:0]       req_fu_i,
    input  logic                       dmem_busy_i,
    input  logic                       ic_stall_i,
    input  logic                       squash_i,
    output logic                       grant_valid_o,
    output logic [$clog2(RS_SIZE)-1:0] grant_idx_o,
    output logic [1:0]                 grant_fu_o,
    output logic [MULT_LAT-1:0]        wb_busy_o
`ifdef EX_SCHED_STATS_EN
    ,
    output logic [31:0]                stat_stall_cycles_o,
    output logic [31:0]                stat_wb_block_cycles_o
`endif
);
    localparam int IDXW = $clog2(RS_SIZE);

    localparam logic [1:0] FU_ALU  = 2'b00;
    localparam logic [1:0] FU_MULT = 2'b01;
    localparam logic [1:0] FU_LOAD = 2'b10;

    logic [IDXW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [MULT_LAT-1:0] wb_busy_q, wb_busy_d;

    logic [RS_SIZE-1:0]  elig;
    logic                found;
    logic [IDXW-1:0]     sel;
    logic [IDXW-1:0]     cand;
    logic [1:0]          sel_fu;

    // Single-cycle ops write back at t+1, so they only need slot 0 free.
    // A multiply's slot t+MULT_LAT can never be claimed yet: nothing else
    // reserves that far ahead and only one op issues per cycle.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            elig[i] = 1'b0;
            if (req_valid_i[i]) begin
                if (req_fu_i[2*i +: 2] == FU_MULT)
                    elig[i] = 1'b1;
                else if (req_fu_i[2*i +: 2] == FU_LOAD)
                    elig[i] = !wb_busy_q[0] && !dmem_busy_i;
                else
                    elig[i] = !wb_busy_q[0];
            end
        end
    end

    // Round-robin scan from rr_ptr; index wraps through the IDXW-bit add.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < RS_SIZE; k++) begin
            cand = rr_ptr_q + IDXW'(k);
            if (!found && elig[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign sel_fu = req_fu_i[{sel, 1'b0} +: 2];

    always_comb begin
        grant_valid_o = found && !ic_stall_i && !squash_i && !reset_i;
        grant_idx_o   = grant_valid_o ? sel    : '0;
        grant_fu_o    = grant_valid_o ? sel_fu : FU_ALU;
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wb_busy_d = wb_busy_q;
        if (squash_i) begin
            rr_ptr_d  = '0;
            wb_busy_d = '0;
        end else if (!ic_stall_i) begin
            wb_busy_d = wb_busy_q >> 1;
            if (grant_valid_o) begin
                rr_ptr_d = sel + IDXW'(1);
                // Claimed after the shift, so it lands MULT_LAT cycles out.
                if (sel_fu == FU_MULT)
                    wb_busy_d[MULT_LAT-2] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr_q  <= '0;
            wb_busy_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wb_busy_q <= wb_busy_d;
        end
    end

    assign wb_busy_o = wb_busy_q;

`ifdef EX_SCHED_STATS_EN
    logic        wb_block;
    logic [31:0] stat_stall_q, stat_wb_block_q;

    // An entry counts as wb-blocked only if slot 0 is the sole reason it waits.
    always_comb begin
        wb_block = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (req_valid_i[i] && wb_busy_q[0] && req_fu_i[2*i +: 2] != FU_MULT &&
                (req_fu_i[2*i +: 2] != FU_LOAD || !dmem_busy_i))
                wb_block = 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            stat_stall_q    <= '0;
            stat_wb_block_q <= '0;
        end else begin
            if (|req_valid_i && !grant_valid_o && !ic_stall_i && !squash_i &&
                stat_stall_q != 32'hFFFF_FFFF)
                stat_stall_q <= stat_stall_q + 32'd1;
            if (wb_block && stat_wb_block_q != 32'hFFFF_FFFF)
                stat_wb_block_q <= stat_wb_block_q + 32'd1;
        end
    end

    assign stat_stall_cycles_o    = stat_stall_q;
    assign stat_wb_block_cycles_o = stat_wb_block_q;
`endif

endmodule
